// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register built as a two-entry skid buffer (main/head + skid).
// Optional feature macro: MEM_WB_X0_SUPPRESS_EN (drop RegWrite for entries targeting x0).
module mem_wb_skid #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            RegWrite,
  input  logic            MemtoReg,
  input  logic [XLEN-1:0] Dataout_Memory,
  input  logic [XLEN-1:0] AluOut_in,
  input  logic [RD_W-1:0] Rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            RegWrite_Out,
  output logic            MemtoReg_Out,
  output logic [XLEN-1:0] DataOut,
  output logic [XLEN-1:0] AluOut,
  output logic [RD_W-1:0] Rd_out,
  output logic [XLEN-1:0] WbData,
  output logic [1:0]      occupancy
);

  typedef struct packed {
    logic            regWrite;
    logic            memToReg;
    logic [XLEN-1:0] memData;
    logic [XLEN-1:0] aluData;
    logic [RD_W-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t nextState;

  logic   accept;
  logic   pop;
  logic   loadMainIn;
  logic   loadMainSkid;
  logic   loadSkid;
  logic   clearHead;
  logic   nextInReady;
  logic   nextOutValid;
  logic [1:0] nextOccupancy;

  entry_t inEntry;
  entry_t skid;
  entry_t headSrc;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Incoming entry, with RegWrite optionally squashed for writes to x0.
  always_comb begin
    inEntry.memToReg = MemtoReg;
    inEntry.memData  = Dataout_Memory;
    inEntry.aluData  = AluOut_in;
    inEntry.rd       = Rd_in;
`ifdef MEM_WB_X0_SUPPRESS_EN
    inEntry.regWrite = RegWrite & (Rd_in != RD_W'(0));
`else
    inEntry.regWrite = RegWrite;
`endif
  end

  // State register; status outputs are registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state     <= nextState;
      in_ready  <= nextInReady;
      out_valid <= nextOutValid;
      occupancy <= nextOccupancy;
    end
  end

  // Next-state logic; flush overrides every other event.
  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) nextState = ONE;
        ONE: begin
          if (accept && !pop)      nextState = TWO;
          else if (!accept && pop) nextState = EMPTY;
        end
        TWO:     if (pop) nextState = ONE;
        default: nextState = EMPTY;
      endcase
    end
  end

  // Datapath actions and next values of the registered status outputs.
  always_comb begin
    loadMainIn    = 1'b0;
    loadMainSkid  = 1'b0;
    loadSkid      = 1'b0;
    clearHead     = 1'b0;
    nextInReady   = (nextState != TWO);
    nextOutValid  = (nextState != EMPTY);
    nextOccupancy = 2'(nextState);
    if (flush) begin
      clearHead = 1'b1;
    end else begin
      unique case (state)
        EMPTY: loadMainIn = accept;
        ONE: begin
          if (accept && pop)  loadMainIn = 1'b1;
          else if (accept)    loadSkid   = 1'b1;
          else if (pop)       clearHead  = 1'b1;
        end
        TWO:     loadMainSkid = pop;
        default: clearHead    = 1'b1;
      endcase
    end
  end

  assign headSrc = loadMainSkid ? skid : inEntry;

  // Head and skid storage; WB data mux is precomputed so WbData is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid         <= '0;
      RegWrite_Out <= 1'b0;
      MemtoReg_Out <= 1'b0;
      DataOut      <= '0;
      AluOut       <= '0;
      Rd_out       <= '0;
      WbData       <= '0;
    end else begin
      if (loadSkid) begin
        skid <= inEntry;
      end
      if (loadMainIn || loadMainSkid) begin
        RegWrite_Out <= headSrc.regWrite;
        MemtoReg_Out <= headSrc.memToReg;
        DataOut      <= headSrc.memData;
        AluOut       <= headSrc.aluData;
        Rd_out       <= headSrc.rd;
        WbData       <= headSrc.memToReg ? headSrc.memData : headSrc.aluData;
      end else if (clearHead) begin
        // Control bits drop to 0; WbData tracks AluOut since MemtoReg_Out is now 0.
        RegWrite_Out <= 1'b0;
        MemtoReg_Out <= 1'b0;
        WbData       <= AluOut;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid: directed scenarios plus random traffic against a queue model.
module tb_mem_wb_skid;

  localparam int unsigned XLEN = 64;
  localparam int unsigned RD_W = 5;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            RegWrite;
  logic            MemtoReg;
  logic [XLEN-1:0] Dataout_Memory;
  logic [XLEN-1:0] AluOut_in;
  logic [RD_W-1:0] Rd_in;
  logic            out_valid;
  logic            out_ready;
  logic            RegWrite_Out;
  logic            MemtoReg_Out;
  logic [XLEN-1:0] DataOut;
  logic [XLEN-1:0] AluOut;
  logic [RD_W-1:0] Rd_out;
  logic [XLEN-1:0] WbData;
  logic [1:0]      occupancy;

  mem_wb_skid #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .Dataout_Memory(Dataout_Memory), .AluOut_in(AluOut_in), .Rd_in(Rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
    .DataOut(DataOut), .AluOut(AluOut), .Rd_out(Rd_out),
    .WbData(WbData), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rw;
    logic            m2r;
    logic [XLEN-1:0] mem;
    logic [XLEN-1:0] alu;
    logic [RD_W-1:0] rd;
  } ent_t;

  ent_t q[$];
  bit   modelReady;
  int   nTests;
  int   nFail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mkEntry();
    ent_t e;
    e.rw  = RegWrite;
    e.m2r = MemtoReg;
    e.mem = Dataout_Memory;
    e.alu = AluOut_in;
    e.rd  = Rd_in;
`ifdef MEM_WB_X0_SUPPRESS_EN
    if (Rd_in == '0) e.rw = 1'b0;
`endif
    return e;
  endfunction

  task automatic checkOutputs();
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(modelReady));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    if (q.size() > 0) begin
      check("RegWrite_Out", 64'(RegWrite_Out), 64'(q[0].rw));
      check("MemtoReg_Out", 64'(MemtoReg_Out), 64'(q[0].m2r));
      check("DataOut", DataOut, q[0].mem);
      check("AluOut", AluOut, q[0].alu);
      check("Rd_out", 64'(Rd_out), 64'(q[0].rd));
      check("WbData", WbData, q[0].m2r ? q[0].mem : q[0].alu);
    end else begin
      check("RegWrite_Out_idle", 64'(RegWrite_Out), 64'(0));
      check("MemtoReg_Out_idle", 64'(MemtoReg_Out), 64'(0));
    end
  endtask

  // One clock: inputs were set before the edge; the model applies the
  // transfer rules at the edge and outputs are checked on the falling edge.
  task automatic step();
    bit acc;
    bit pp;
    @(posedge clk);
    acc = rst_n && in_valid && modelReady;
    pp  = rst_n && (q.size() > 0) && out_ready;
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else begin
        if (pp)  q.delete(0);
        if (acc) q.push_back(mkEntry());
      end
      modelReady = (q.size() < 2);
    end
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic setIn(input bit v, input bit rw, input bit m2r,
                       input logic [63:0] mem, input logic [63:0] alu, input logic [4:0] rd);
    in_valid       = v;
    RegWrite       = rw;
    MemtoReg       = m2r;
    Dataout_Memory = mem;
    AluOut_in      = alu;
    Rd_in          = rd;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_RegWrite_Out"}, 64'(RegWrite_Out), 64'(0));
    check({tag, "_MemtoReg_Out"}, 64'(MemtoReg_Out), 64'(0));
    check({tag, "_DataOut"}, DataOut, 64'(0));
    check({tag, "_AluOut"}, AluOut, 64'(0));
    check({tag, "_Rd_out"}, 64'(Rd_out), 64'(0));
    check({tag, "_WbData"}, WbData, 64'(0));
    check({tag, "_occupancy"}, 64'(occupancy), 64'(0));
  endtask

  initial begin
    nTests     = 0;
    nFail      = 0;
    modelReady = 1'b0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    setIn(0, 0, 0, 64'd0, 64'd0, 5'd0);

    // Reset state and first edge after release
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    check("in_ready_before_edge", 64'(in_ready), 64'(0));
    step();
    check("in_ready_after_release", 64'(in_ready), 64'(1));

    // Single entry with memory write-back
    out_ready = 1'b1;
    setIn(1, 1, 1, 64'hDEAD_BEEF_0000_0001, 64'h55, 5'd7);
    step();
    check("single_out_valid", 64'(out_valid), 64'(1));
    check("single_WbData", WbData, 64'hDEAD_BEEF_0000_0001);
    check("single_Rd_out", 64'(Rd_out), 64'(7));
    setIn(0, 0, 0, 64'd0, 64'd0, 5'd0);
    step();
    check("single_drained", 64'(out_valid), 64'(0));

    // Backpressure: A then B held, extra offer ignored, then drained in order
    out_ready = 1'b0;
    setIn(1, 1, 0, 64'hA0, 64'd1, 5'd3);
    step();
    setIn(1, 1, 0, 64'hB0, 64'd2, 5'd4);
    step();
    check("bp_occupancy", 64'(occupancy), 64'(2));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_AluOut_A", AluOut, 64'd1);
    setIn(1, 1, 0, 64'hC0, 64'd99, 5'd5);
    step();
    check("bp_hold_AluOut", AluOut, 64'd1);
    check("bp_hold_occupancy", 64'(occupancy), 64'(2));
    setIn(0, 0, 0, 64'd0, 64'd0, 5'd0);
    out_ready = 1'b1;
    step();
    check("bp_AluOut_B", AluOut, 64'd2);
    check("bp_occ_after_popA", 64'(occupancy), 64'(1));
    step();
    check("bp_empty", 64'(out_valid), 64'(0));

    // Flush with two held entries and a concurrent offer
    out_ready = 1'b0;
    setIn(1, 1, 1, 64'h11, 64'h12, 5'd9);
    step();
    setIn(1, 1, 1, 64'h21, 64'h22, 5'd10);
    step();
    check("flush_pre_occ", 64'(occupancy), 64'(2));
    flush     = 1'b1;
    out_ready = 1'b1;
    setIn(1, 1, 1, 64'h31, 64'h32, 5'd11);
    step();
    check("flush_occupancy", 64'(occupancy), 64'(0));
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_RegWrite_Out", 64'(RegWrite_Out), 64'(0));
    flush = 1'b0;
    setIn(0, 0, 0, 64'd0, 64'd0, 5'd0);
    step();

    // Asynchronous reset while holding two entries
    out_ready = 1'b0;
    setIn(1, 1, 1, 64'h41, 64'h42, 5'd12);
    step();
    setIn(1, 1, 0, 64'h51, 64'h52, 5'd13);
    step();
    check("areset_pre_occ", 64'(occupancy), 64'(2));
    setIn(0, 0, 0, 64'd0, 64'd0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("areset");
    q.delete();
    modelReady = 1'b0;
    @(negedge clk);
    checkAllZero("areset_held");
    rst_n = 1'b1;
    step();
    check("areset_in_ready_first_edge", 64'(in_ready), 64'(1));

    // Write to x0
    out_ready = 1'b1;
    setIn(1, 1, 0, 64'h0, 64'd5, 5'd0);
    step();
`ifdef MEM_WB_X0_SUPPRESS_EN
    check("x0_RegWrite_Out", 64'(RegWrite_Out), 64'(0));
`else
    check("x0_RegWrite_Out", 64'(RegWrite_Out), 64'(1));
`endif
    setIn(0, 0, 0, 64'd0, 64'd0, 5'd0);
    step();

    // Streaming: one entry in and one out every cycle, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      setIn(1, 1, 0, 64'hF00 + 64'(i), 64'(i), 5'(i + 1));
      step();
      check("stream_AluOut", AluOut, 64'(i));
      check("stream_occupancy", 64'(occupancy), 64'(1));
      check("stream_out_valid", 64'(out_valid), 64'(1));
    end
    setIn(0, 0, 0, 64'd0, 64'd0, 5'd0);
    step();

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      setIn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
